// File: rtl/soc_event_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | APB_BUS : 32-bit APB register bus bundle with Master/Slave modports.  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface APB_BUS;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/soc_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | soc_event_arbiter : round-robin event collector with APB control;     |
// | software event slot compiled in with SOC_EVT_SW_EVENT_EN. Rev 1.0     |
// +-----------------------------------------------------------------------+
module soc_event_arbiter #(
    parameter int N_EVENTS     = 32,
    parameter int EVT_ID_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_EVENTS-1:0]     events_i,
    output logic                    event_valid_o,
    output logic [EVT_ID_WIDTH-1:0] event_data_o,
    input  logic                    event_ready_i,
    output logic                    err_o,
    APB_BUS.Slave                   apb_slave
);

`ifdef SOC_EVT_SW_EVENT_EN
    localparam int N_SLOTS = N_EVENTS + 1;
`else
    localparam int N_SLOTS = N_EVENTS;
`endif
    localparam int LG_W = $clog2(N_EVENTS + 1);
    localparam logic [LG_W-1:0] LG_RESET = LG_W'(N_EVENTS);

    if (N_EVENTS < 1 || N_EVENTS > 32 || N_EVENTS > (1 << EVT_ID_WIDTH)) begin : g_param_check
        $error("soc_event_arbiter: unsupported N_EVENTS/EVT_ID_WIDTH");
    end

    logic [N_EVENTS-1:0]     pending;
    logic [N_EVENTS-1:0]     evt_en;
    logic [N_EVENTS-1:0]     err_bits;
    logic                    out_valid;
    logic [EVT_ID_WIDTH-1:0] out_id;
    logic [LG_W-1:0]         last_grant;

    logic [N_SLOTS-1:0]      req;
    logic                    found;
    logic [LG_W-1:0]         win_idx;
    logic [EVT_ID_WIDTH-1:0] win_id;
    logic                    load;
    logic [N_EVENTS-1:0]     grant_hw;
    logic [N_EVENTS-1:0]     sample;
    logic [3:0]              reg_idx;
    logic                    wr_en;
    logic                    rd_en;
    logic                    wr_evt_en;
    logic                    wr_sw;
    logic                    rd_err;
    logic [31:0]             prdata_c;

    assign reg_idx   = apb_slave.paddr[5:2];
    assign wr_en     = apb_slave.psel & apb_slave.penable & apb_slave.pwrite;
    assign rd_en     = apb_slave.psel & apb_slave.penable & ~apb_slave.pwrite;
    assign wr_evt_en = wr_en && (reg_idx == 4'd0);
    assign wr_sw     = wr_en && (reg_idx == 4'd1);
    assign rd_err    = rd_en && (reg_idx == 4'd2);

    assign apb_slave.pready  = 1'b1;
    assign apb_slave.pslverr = 1'b0;
    assign apb_slave.prdata  = prdata_c;

`ifdef SOC_EVT_SW_EVENT_EN
    logic                    sw_pending;
    logic [EVT_ID_WIDTH-1:0] sw_id;
    logic                    err_sw;
    logic                    rd_err_sw;
    logic                    sw_accept;
    logic                    sw_grant;

    assign rd_err_sw = rd_en && (reg_idx == 4'd3);
    assign sw_accept = wr_sw & ~sw_pending;
    assign sw_grant  = load & found & (int'(win_idx) == N_EVENTS);
    assign req       = {sw_pending, pending};
    assign err_o     = (|err_bits) | err_sw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_pending <= 1'b0;
            sw_id      <= '0;
            err_sw     <= 1'b0;
        end else begin
            if (sw_accept) begin
                sw_pending <= 1'b1;
                sw_id      <= apb_slave.pwdata[EVT_ID_WIDTH-1:0];
            end else if (sw_grant) begin
                sw_pending <= 1'b0;
            end
            // A colliding write wins over a same-cycle read-clear.
            err_sw <= (err_sw & ~rd_err_sw) | (wr_sw & sw_pending);
        end
    end
`else
    assign req   = pending;
    assign err_o = |err_bits;
`endif

    always_comb begin
        prdata_c = '0;
        case (reg_idx)
            4'd0: prdata_c[N_EVENTS-1:0] = evt_en;
            4'd2: prdata_c[N_EVENTS-1:0] = err_bits;
`ifdef SOC_EVT_SW_EVENT_EN
            4'd3: prdata_c[0] = err_sw;
`endif
            default: prdata_c = '0;
        endcase
    end

    // Round-robin search starting one past the last granted slot.
    always_comb begin
        int                 start;
        int                 idx;
        logic [N_SLOTS-1:0] req_sh;
        found   = 1'b0;
        win_idx = '0;
        start   = (int'(last_grant) >= N_SLOTS - 1) ? 0 : int'(last_grant) + 1;
        for (int k = 0; k < N_SLOTS; k++) begin
            idx = start + k;
            if (idx >= N_SLOTS) begin
                idx = idx - N_SLOTS;
            end
            req_sh = req >> idx;
            if (!found && req_sh[0]) begin
                found   = 1'b1;
                win_idx = LG_W'(idx);
            end
        end
    end

    always_comb begin
        win_id = EVT_ID_WIDTH'(win_idx);
`ifdef SOC_EVT_SW_EVENT_EN
        if (int'(win_idx) == N_EVENTS) begin
            win_id = sw_id;
        end
`endif
    end

    assign load     = ~out_valid | event_ready_i;
    assign sample   = events_i & evt_en;
    assign grant_hw = (load && found) ? (N_EVENTS'(1) << win_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending    <= '0;
            evt_en     <= '0;
            err_bits   <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            last_grant <= LG_RESET;
        end else begin
            // A fresh pulse on the slot being granted re-arms it without error.
            pending  <= (pending & ~grant_hw) | sample;
            err_bits <= (err_bits & ~{N_EVENTS{rd_err}}) | (sample & pending & ~grant_hw);
            if (wr_evt_en) begin
                evt_en <= apb_slave.pwdata[N_EVENTS-1:0];
            end
            if (load) begin
                out_valid <= found;
                out_id    <= found ? win_id : '0;
                if (found) begin
                    last_grant <= win_idx;
                end
            end
        end
    end

    assign event_valid_o = out_valid;
    assign event_data_o  = out_id;

    logic unused_bits;
    assign unused_bits = ^{apb_slave.paddr[31:6], apb_slave.paddr[1:0], apb_slave.pwdata, wr_sw};

endmodule
`default_nettype wire

// File: tb/tb_soc_event_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_soc_event_arbiter : scoreboard bench for soc_event_arbiter.        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_soc_event_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] events;
    logic        ev_valid;
    logic [7:0]  ev_data;
    logic        ev_ready;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    APB_BUS apb();

    soc_event_arbiter #(
        .N_EVENTS     (32),
        .EVT_ID_WIDTH (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .events_i      (events),
        .event_valid_o (ev_valid),
        .event_data_o  (ev_data),
        .event_ready_i (ev_ready),
        .err_o         (err),
        .apb_slave     (apb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every accepted transfer must match the next expected ID.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard_unexpected actual=0x%02h required=none", ev_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    failures = failures + 1;
                    $display("FAIL scoreboard_id actual=0x%02h required=0x%02h", ev_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = addr;
        apb.pwdata  = data;
        tick();
        apb.penable = 1'b1;
        tick();
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = addr;
        tick();
        apb.penable = 1'b1;
        #1;
        data = apb.prdata;
        @(posedge clk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [31:0] mask);
        events = mask;
        tick();
        events = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        sw_en;
`ifdef SOC_EVT_SW_EVENT_EN
        sw_en = 1'b1;
`else
        sw_en = 1'b0;
`endif
        rst_n       = 1'b0;
        events      = '0;
        ev_ready    = 1'b1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        tick();
        tick();
        check("reset_valid", {31'd0, ev_valid}, 32'd0);
        check("reset_data", {24'd0, ev_data}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single event latency
        apb_write(32'h00, 32'hFFFF_FFFF);
        apb_read(32'h00, rd);
        check("evt_en_readback", rd, 32'hFFFF_FFFF);
        apb_read(32'h10, rd);
        check("unmapped_read", rd, 32'd0);
        exp_q.push_back(8'h05);
        pulse(32'h0000_0020);
        check("lat_not_yet", {31'd0, ev_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, ev_valid}, 32'd1);
        check("lat_data", {24'd0, ev_data}, 32'h05);
        tick();
        check("lat_one_cycle", {31'd0, ev_valid}, 32'd0);

        // Back-to-back round-robin
        reset_dut();
        apb_write(32'h00, 32'hFFFF_FFFF);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd31);
        pulse(32'h8000_0088);
        tick();
        check("b2b_id0", {23'd0, ev_valid, ev_data}, {23'd0, 1'b1, 8'd3});
        tick();
        check("b2b_id1", {23'd0, ev_valid, ev_data}, {23'd0, 1'b1, 8'd7});
        tick();
        check("b2b_id2", {23'd0, ev_valid, ev_data}, {23'd0, 1'b1, 8'd31});
        tick();
        check("b2b_idle", {31'd0, ev_valid}, 32'd0);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd7);
        pulse(32'h0000_0088);
        tick();
        check("rr_wrap_id0", {24'd0, ev_data}, 32'd3);
        tick();
        check("rr_wrap_id1", {24'd0, ev_data}, 32'd7);
        tick();

        // Overflow error with output stalled by event 1
        ev_ready = 1'b0;
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        pulse(32'h0000_0002);
        tick();
        pulse(32'h0000_0004);
        repeat (3) tick();
        pulse(32'h0000_0004);
        tick();
        check("ovf_err_o", {31'd0, err}, 32'd1);
        apb_read(32'h08, rd);
        check("ovf_err_read", rd, 32'h0000_0004);
        check("ovf_err_o_cleared", {31'd0, err}, 32'd0);
        apb_read(32'h08, rd);
        check("ovf_err_reread", rd, 32'd0);
        ev_ready = 1'b1;
        repeat (5) tick();

        // Stall hold then reset mid-stall
        reset_dut();
        apb_write(32'h00, 32'hFFFF_FFFF);
        ev_ready = 1'b0;
        pulse(32'h0000_0200);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_hold_%0d", i), {23'd0, ev_valid, ev_data}, {23'd0, 1'b1, 8'h09});
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_valid", {31'd0, ev_valid}, 32'd0);
        check("reset_mid_data", {24'd0, ev_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev_ready = 1'b1;
        repeat (4) tick();

        // Software event collision while output held by event 4
        apb_write(32'h00, 32'hFFFF_FFFF);
        ev_ready = 1'b0;
        exp_q.push_back(8'd4);
        pulse(32'h0000_0010);
        tick();
        apb_write(32'h04, 32'h0000_00A5);
        apb_write(32'h04, 32'h0000_00A5);
        if (sw_en) begin
            exp_q.push_back(8'hA5);
        end
        check("sw_err_o", {31'd0, err}, {31'd0, sw_en});
        apb_read(32'h0C, rd);
        check("sw_err_read", rd, {31'd0, sw_en});
        apb_read(32'h0C, rd);
        check("sw_err_reread", rd, 32'd0);
        apb_read(32'h04, rd);
        check("sw_evt_read_zero", rd, 32'd0);
        ev_ready = 1'b1;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            tick();
        end
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_event_arbiter.md
SOC_EVENT_ARBITER -- requirements
Module: soc_event_arbiter

Interface
REQ-001 SHALL have parameter N_EVENTS, default 32, number of hardware event sources (1..32).
REQ-002 SHALL have parameter EVT_ID_WIDTH, default 8, event ID width; N_EVENTS SHALL be no greater than 2^EVT_ID_WIDTH.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port events_i, input, N_EVENTS, one-cycle event pulses; bit i is source i.
REQ-006 SHALL have port event_valid_o, output, 1, event ID available.
REQ-007 SHALL have port event_data_o, output, EVT_ID_WIDTH, event ID.
REQ-008 SHALL have port event_ready_i, input, 1, consumer accepts the event; driven by the event FIFO not-full grant.
REQ-009 SHALL have port err_o, output, 1, OR of all sticky error bits.
REQ-010 SHALL have port apb_slave, APB_BUS.Slave, 32-bit; register index is paddr[5:2].

Function
REQ-011 SHALL sample events_i[i] into pending[i] at a clock edge only when EVT_EN[i] is 1.
REQ-012 SHALL set ERR[i] sticky when a sampled pulse finds pending[i] already 1; the pulse is dropped.
REQ-013 SHALL keep an output register (valid, id), loaded at an edge when it is empty or being accepted (event_valid_o & event_ready_i).
REQ-014 SHALL select the load winner round-robin among pending slots 0..N_EVENTS-1, plus slot N_EVENTS for the software event.
REQ-015 SHALL start the search at slot last_grant+1 mod (N_EVENTS+1); last_grant resets to N_EVENTS, so slot 0 wins first.
REQ-016 SHALL clear the winner's pending bit at the load edge; a pulse on the same source in the same cycle re-sets it with no error.
REQ-017 SHALL give latency pulse at edge k -> pending at edge k -> event_valid_o high after edge k+1, when the output is free.
REQ-018 SHALL emit ID = i for hardware slot i, and the stored software ID for slot N_EVENTS.
REQ-019 SHALL hold event_data_o stable while event_valid_o=1 and event_ready_i=0; no pending bit is lost while stalled.
REQ-020 SHALL sustain back-to-back transfers of one event per cycle while event_ready_i stays 1.
REQ-021 SHALL retain pending bits when EVT_EN[i] is cleared and still emit them; only new pulses are blocked.
REQ-022 SHALL implement register 0x00 EVT_EN: read/write, reset 0.
REQ-023 SHALL implement register 0x04 SW_EVT: write-only; a write of pwdata[EVT_ID_WIDTH-1:0] sets sw_pending and sw_id.
REQ-024 SHALL, on an SW_EVT write while sw_pending=1, drop the write and set ERR_SW sticky.
REQ-025 SHALL implement register 0x08 ERR (bit i = ERR[i]) and register 0x0C ERR_SW (bit0): both read-to-clear in the access cycle.
REQ-026 SHALL keep an error bit set when a new error occurs in the same cycle as its read-clear.
REQ-027 SHALL perform APB accesses on psel & penable; pready=1; pslverr=0; unmapped reads return 0; unmapped writes are ignored.

Reset
REQ-028 SHALL, with rst_ni low, asynchronously clear pending, sw_pending, sw_id, EVT_EN, ERR, ERR_SW and the output register.
REQ-029 SHALL hold event_valid_o=0, event_data_o=0, err_o=0 and last_grant=N_EVENTS in reset; reset mid-transfer discards the held event.

Configuration
REQ-030 SHALL compile the software-event feature (SW_EVT, ERR_SW, slot N_EVENTS) only when SOC_EVT_SW_EVENT_EN is defined.
REQ-031 SHALL, without SOC_EVT_SW_EVENT_EN, ignore writes to 0x04, return 0 when reading 0x0C, and run round-robin over N_EVENTS slots only.

Verification
REQ-032 SHALL cover: EVT_EN=0xFFFFFFFF, pulse events_i[5], ready=1 -> event_valid_o high two edges later with data 0x05 for one cycle.
REQ-033 SHALL cover: all enabled, pulse bits 3, 7, 31 together, ready=1 -> IDs 3, 7, 31 on consecutive cycles; then pulse 3 and 7 -> order 3, 7.
REQ-034 SHALL cover: ready=0, pulse bit 2 twice, four cycles apart -> ERR reads 0x00000004 and err_o=1; a second ERR read returns 0; only one ID 2 is emitted after ready=1.
REQ-035 SHALL cover: ready=0 for 10 cycles with event 9 held -> data stays 0x09 throughout; assert rst_ni mid-stall -> valid drops immediately.
REQ-036 SHALL cover, with SOC_EVT_SW_EVENT_EN: write SW_EVT=0xA5 twice before the event is accepted -> one ID 0xA5 emitted and ERR_SW reads 1; without the macro -> no event emitted.
